// File: rtl/cdb_rs_pkg.sv
// Shared types for the CDB-snooping reservation station: dispatch/issue packets,
// entry layout, CDB broadcast and the operand wake-up helper.
package cdb_rs_pkg;

  localparam int unsigned TAG_W = 6;
  localparam int unsigned VAL_W = 32;

  typedef enum logic [2:0] {FuAlu, FuMul, FuLoad, FuStore, FuBranch} fu_opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    fu_opcode_e  fu_opcode;
    logic [4:0]  dest_reg;
  } id_ex_packet_t;

  typedef struct packed {
    logic [VAL_W-1:0] val;
    logic [TAG_W-1:0] tag;
    logic             ready;
  } rs_operand_t;

  typedef struct packed {
    logic [TAG_W-1:0] dest_tag;
    rs_operand_t      opa;
    rs_operand_t      opb;
    id_ex_packet_t    payload;
  } rs_dispatch_packet_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] dest_tag;
    rs_operand_t      opa;
    rs_operand_t      opb;
    id_ex_packet_t    payload;
  } rs_entry_t;

  typedef struct packed {
    logic [TAG_W-1:0] dest_tag;
    logic [VAL_W-1:0] opa_val;
    logic [VAL_W-1:0] opb_val;
    id_ex_packet_t    payload;
  } rs_issue_packet_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] value;
    fu_opcode_e       fu_opcode;
    logic             clear;
  } cdb_output_t;

  // Capture a broadcast value into a still-waiting operand; ready operands are kept.
  function automatic rs_operand_t wake_operand(input rs_operand_t op, input cdb_output_t cdb);
    rs_operand_t res;
    res = op;
    if (cdb.valid && !op.ready && (op.tag == cdb.tag)) begin
      res.val   = cdb.value;
      res.ready = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cdb_rs_psel.sv
// Lowest-index priority selector: one-hot grant of the lowest set request bit.
module cdb_rs_psel #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/cdb_rs.sv
// Reservation station: holds dispatched instructions, wakes operands from the CDB,
// and issues the lowest-index fully-ready entry to a single functional unit.
module cdb_rs
  import cdb_rs_pkg::*;
#(
  parameter int unsigned RS_SIZE = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        dispatch_valid,
  input  rs_dispatch_packet_t         dispatch_pkt,
  output logic                        dispatch_ready,
  input  cdb_output_t                 cdb_in,
  output logic                        issue_valid,
  output rs_issue_packet_t            issue_pkt,
  input  logic                        issue_ready,
  output logic [$clog2(RS_SIZE):0]    free_count
);

  localparam int unsigned CntW = $clog2(RS_SIZE) + 1;

  rs_entry_t           entries_q [RS_SIZE];
  rs_entry_t           entries_d [RS_SIZE];
  logic [RS_SIZE-1:0]  free_req, rdy_req, free_gnt, issue_gnt;
  logic                free_any, issue_any;
  logic                dispatch_fire, issue_fire;
  logic [CntW-1:0]     valid_cnt;

  // Opcode and clear are not needed to match tags.
  logic unused_cdb;
  assign unused_cdb = ^{cdb_in.fu_opcode, cdb_in.clear};

  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      free_req[i] = !entries_q[i].valid;
      rdy_req[i]  = entries_q[i].valid && entries_q[i].opa.ready && entries_q[i].opb.ready;
    end
  end

  cdb_rs_psel #(.N(RS_SIZE)) u_free_sel (
    .req (free_req),
    .gnt (free_gnt),
    .any (free_any)
  );

  cdb_rs_psel #(.N(RS_SIZE)) u_issue_sel (
    .req (rdy_req),
    .gnt (issue_gnt),
    .any (issue_any)
  );

  always_comb begin
    valid_cnt = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      valid_cnt = valid_cnt + CntW'(entries_q[i].valid);
    end
  end

  assign free_count     = CntW'(RS_SIZE) - valid_cnt;
  // Registered occupancy only: a slot freed by this cycle's issue is not offered.
  assign dispatch_ready = free_any;
  assign issue_valid    = issue_any;
  assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
  assign issue_fire     = issue_valid && issue_ready;

  always_comb begin
    issue_pkt = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (issue_gnt[i]) begin
        issue_pkt.dest_tag = entries_q[i].dest_tag;
        issue_pkt.opa_val  = entries_q[i].opa.val;
        issue_pkt.opb_val  = entries_q[i].opb.val;
        issue_pkt.payload  = entries_q[i].payload;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        entries_d[i].opa = wake_operand(entries_q[i].opa, cdb_in);
        entries_d[i].opb = wake_operand(entries_q[i].opb, cdb_in);
      end
      if (issue_fire && issue_gnt[i]) begin
        entries_d[i].valid = 1'b0;
      end
      if (dispatch_fire && free_gnt[i]) begin
        entries_d[i].valid    = 1'b1;
        entries_d[i].dest_tag = dispatch_pkt.dest_tag;
        entries_d[i].opa      = wake_operand(dispatch_pkt.opa, cdb_in);
        entries_d[i].opb      = wake_operand(dispatch_pkt.opb, cdb_in);
        entries_d[i].payload  = dispatch_pkt.payload;
      end
      if (flush) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_rs.sv
// Directed bench for cdb_rs: single-entry vector table plus hand sequences for
// wake-up, full/drop, in-order drain, flush and asynchronous reset.
module tb_cdb_rs;
  import cdb_rs_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic                flush;
  logic                dispatch_valid;
  rs_dispatch_packet_t dispatch_pkt;
  logic                dispatch_ready;
  cdb_output_t         cdb_in;
  logic                issue_valid;
  rs_issue_packet_t    issue_pkt;
  logic                issue_ready;
  logic [3:0]          free_count;

  int tests  = 0;
  int failed = 0;

  cdb_rs #(.RS_SIZE(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .dispatch_valid (dispatch_valid),
    .dispatch_pkt   (dispatch_pkt),
    .dispatch_ready (dispatch_ready),
    .cdb_in         (cdb_in),
    .issue_valid    (issue_valid),
    .issue_pkt      (issue_pkt),
    .issue_ready    (issue_ready),
    .free_count     (free_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  dest;
    logic        a_rdy;
    logic [5:0]  a_tag;
    logic [31:0] a_val;
    logic        b_rdy;
    logic [5:0]  b_tag;
    logic [31:0] b_val;
    logic        cdb_v;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_dispatch(input logic [5:0] dest, input logic a_rdy, input logic [5:0] a_tag,
                              input logic [31:0] a_val, input logic b_rdy,
                              input logic [5:0] b_tag, input logic [31:0] b_val);
    dispatch_valid           = 1'b1;
    dispatch_pkt             = '0;
    dispatch_pkt.dest_tag    = dest;
    dispatch_pkt.opa.ready   = a_rdy;
    dispatch_pkt.opa.tag     = a_tag;
    dispatch_pkt.opa.val     = a_val;
    dispatch_pkt.opb.ready   = b_rdy;
    dispatch_pkt.opb.tag     = b_tag;
    dispatch_pkt.opb.val     = b_val;
    dispatch_pkt.payload.pc  = {26'd0, dest};
  endtask

  task automatic set_cdb(input logic v, input logic [5:0] tag, input logic [31:0] value);
    cdb_in       = '0;
    cdb_in.valid = v;
    cdb_in.tag   = tag;
    cdb_in.value = value;
  endtask

  initial begin
    //           dest a_rdy a_tag a_val       b_rdy b_tag b_val  cdb_v tag val        exp_a      exp_b
    vecs[0] = '{6'd3, 1'b1, 6'd0, 32'd5,     1'b1, 6'd0, 32'd7, 1'b0, 6'd0, 32'd0,    32'd5,     32'd7};
    vecs[1] = '{6'd4, 1'b0, 6'd6, 32'd0,     1'b1, 6'd0, 32'd1, 1'b1, 6'd6, 32'd9,    32'd9,     32'd1};
    vecs[2] = '{6'd5, 1'b0, 6'd10, 32'd0,    1'b0, 6'd10, 32'd0, 1'b1, 6'd10, 32'h55, 32'h55,    32'h55};
    vecs[3] = '{6'd6, 1'b1, 6'd12, 32'h11,   1'b0, 6'd12, 32'd0, 1'b1, 6'd12, 32'h99, 32'h11,    32'h99};

    reset          = 1'b0;
    flush          = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_pkt   = '0;
    issue_ready    = 1'b0;
    set_cdb(1'b0, 6'd0, 32'd0);
    #12;
    check("reset_free_count", 64'(free_count), 64'd8);
    check("reset_issue_valid", 64'(issue_valid), 64'd0);
    check("reset_dispatch_ready", 64'(dispatch_ready), 64'd1);
    check("reset_issue_pkt", 64'(issue_pkt.opa_val), 64'd0);
    reset = 1'b1;
    tick();

    // Single-entry table: dispatch (optionally with same-cycle CDB), issue, drain.
    for (int v = 0; v < 4; v++) begin
      set_dispatch(vecs[v].dest, vecs[v].a_rdy, vecs[v].a_tag, vecs[v].a_val,
                   vecs[v].b_rdy, vecs[v].b_tag, vecs[v].b_val);
      set_cdb(vecs[v].cdb_v, vecs[v].cdb_tag, vecs[v].cdb_val);
      tick();
      dispatch_valid = 1'b0;
      set_cdb(1'b0, 6'd0, 32'd0);
      check($sformatf("v%0d_issue_valid", v), 64'(issue_valid), 64'd1);
      check($sformatf("v%0d_opa", v), 64'(issue_pkt.opa_val), 64'(vecs[v].exp_a));
      check($sformatf("v%0d_opb", v), 64'(issue_pkt.opb_val), 64'(vecs[v].exp_b));
      check($sformatf("v%0d_dest", v), 64'(issue_pkt.dest_tag), 64'(vecs[v].dest));
      check($sformatf("v%0d_free_busy", v), 64'(free_count), 64'd7);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      check($sformatf("v%0d_free_after", v), 64'(free_count), 64'd8);
      check($sformatf("v%0d_idle_after", v), 64'(issue_valid), 64'd0);
    end

    // Wake-up from a later broadcast; invalid broadcast must be ignored.
    set_dispatch(6'd1, 1'b0, 6'd4, 32'd0, 1'b1, 6'd0, 32'd2);
    tick();
    dispatch_valid = 1'b0;
    check("wake_wait", 64'(issue_valid), 64'd0);
    set_cdb(1'b0, 6'd4, 32'hBEEF);
    tick();
    check("wake_invalid_cdb", 64'(issue_valid), 64'd0);
    set_cdb(1'b1, 6'd4, 32'hDEAD);
    tick();
    set_cdb(1'b0, 6'd0, 32'd0);
    check("wake_issue_valid", 64'(issue_valid), 64'd1);
    check("wake_opa", 64'(issue_pkt.opa_val), 64'hDEAD);
    check("wake_opb", 64'(issue_pkt.opb_val), 64'd2);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("wake_drained", 64'(free_count), 64'd8);

    // Fill all entries waiting on tag 2, then overflow.
    for (int i = 0; i < 8; i++) begin
      set_dispatch(6'(i), 1'b0, 6'd2, 32'd0, 1'b1, 6'd0, 32'(i));
      tick();
    end
    check("full_dispatch_ready", 64'(dispatch_ready), 64'd0);
    check("full_free_count", 64'(free_count), 64'd0);
    set_dispatch(6'd9, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    tick();
    dispatch_valid = 1'b0;
    check("full_drop", 64'(free_count), 64'd0);
    check("full_none_ready", 64'(issue_valid), 64'd0);
    set_cdb(1'b1, 6'd2, 32'h20);
    tick();
    set_cdb(1'b0, 6'd0, 32'd0);
    issue_ready = 1'b1;
    // A dispatch alongside the first issue from a full station must be dropped.
    set_dispatch(6'd20, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_valid", i), 64'(issue_valid), 64'd1);
      check($sformatf("drain%0d_dest", i), 64'(issue_pkt.dest_tag), 64'(i));
      check($sformatf("drain%0d_opa", i), 64'(issue_pkt.opa_val), 64'h20);
      tick();
      dispatch_valid = 1'b0;
    end
    issue_ready = 1'b0;
    check("drain_done_valid", 64'(issue_valid), 64'd0);
    check("drain_done_free", 64'(free_count), 64'd8);

    // Flush with concurrent dispatch, wake and issue handshake.
    for (int i = 0; i < 4; i++) begin
      set_dispatch(6'(i + 30), 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd0);
      tick();
    end
    check("flush_held", 64'(free_count), 64'd4);
    set_dispatch(6'd40, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    set_cdb(1'b1, 6'd3, 32'h33);
    issue_ready = 1'b1;
    flush       = 1'b1;
    tick();
    flush          = 1'b0;
    dispatch_valid = 1'b0;
    issue_ready    = 1'b0;
    set_cdb(1'b0, 6'd0, 32'd0);
    check("flush_free", 64'(free_count), 64'd8);
    check("flush_issue_valid", 64'(issue_valid), 64'd0);
    tick();
    check("flush_stays_idle", 64'(issue_valid), 64'd0);

    // Asynchronous reset with entries held, checked between clock edges.
    for (int i = 0; i < 3; i++) begin
      set_dispatch(6'(i), 1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'd0);
      tick();
    end
    dispatch_valid = 1'b0;
    check("rst_pre_free", 64'(free_count), 64'd5);
    #1;
    reset = 1'b0;
    #1;
    check("rst_async_free", 64'(free_count), 64'd8);
    check("rst_async_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_async_dispatch_ready", 64'(dispatch_ready), 64'd1);
    reset = 1'b1;
    tick();
    check("rst_after_free", 64'(free_count), 64'd8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
